// File: rtl/rshift_round_sat.sv
// Rounding arithmetic right shift of a wide two's-complement sample, saturated to
// DATA_WIDTH bits. Two-stage valid/ready pipeline with a saturation event counter.
module rshift_round_sat #(
   parameter int DATA_WIDTH    = 16,
   parameter int RSHIFT_AMOUNT = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [2*DATA_WIDTH-1:0] D_in,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic [DATA_WIDTH-1:0]   D_out,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    sat_flag,
   output logic [7:0]              sat_count,
   input  logic                    clr_count
);

   localparam int IW = 2*DATA_WIDTH;
   localparam int WW = IW + 1;

   logic [WW-1:0]         rnd_add;
   logic [WW-1:0]         ext_sum;
   logic [WW-1:0]         rounded;
   logic [1:0]            vld_pipe_q, vld_pipe_d;
   logic [WW-1:0]         s1_data_q, s1_data_d;
   logic [DATA_WIDTH-1:0] d_out_q, d_out_d;
   logic                  sat_flag_q, sat_flag_d;
   logic [7:0]            sat_count_q, sat_count_d;
   logic                  en;
   logic                  in_range;
   logic                  sat;
   logic [DATA_WIDTH-1:0] s2_val;

   generate
      if (RSHIFT_AMOUNT > 0) begin : g_rnd
         assign rnd_add = WW'(1) << (RSHIFT_AMOUNT - 1);
      end else begin : g_nornd
         assign rnd_add = '0;
      end
   endgenerate

   // One guard bit above the input width makes the half-LSB add overflow-free.
   always_comb begin
      ext_sum = {D_in[IW-1], D_in} + rnd_add;
      rounded = WW'($signed(ext_sum) >>> RSHIFT_AMOUNT);
   end

   // In range iff every bit from the output sign position upward matches.
   always_comb begin
      in_range = (&s1_data_q[WW-1:DATA_WIDTH-1]) | ~(|s1_data_q[WW-1:DATA_WIDTH-1]);
      sat      = ~in_range;
      if (!sat)
         s2_val = s1_data_q[DATA_WIDTH-1:0];
      else if (s1_data_q[WW-1])
         s2_val = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      else
         s2_val = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   end

   assign en = ~vld_pipe_q[1] | out_ready;

   always_comb begin
      vld_pipe_d  = vld_pipe_q;
      s1_data_d   = s1_data_q;
      d_out_d     = d_out_q;
      sat_flag_d  = sat_flag_q;
      sat_count_d = sat_count_q;
      if (en) begin
         vld_pipe_d = {vld_pipe_q[0], in_valid};
         s1_data_d  = rounded;
         d_out_d    = s2_val;
         sat_flag_d = sat & vld_pipe_q[0];
      end
      if (clr_count)
         sat_count_d = '0;
      else if (vld_pipe_q[1] && out_ready && sat_flag_q && sat_count_q != 8'hFF)
         sat_count_d = sat_count_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_pipe_q  <= '0;
         s1_data_q   <= '0;
         d_out_q     <= '0;
         sat_flag_q  <= 1'b0;
         sat_count_q <= '0;
      end else begin
         vld_pipe_q  <= vld_pipe_d;
         s1_data_q   <= s1_data_d;
         d_out_q     <= d_out_d;
         sat_flag_q  <= sat_flag_d;
         sat_count_q <= sat_count_d;
      end
   end

   assign in_ready  = en;
   assign out_valid = vld_pipe_q[1];
   assign D_out     = d_out_q;
   assign sat_flag  = sat_flag_q;
   assign sat_count = sat_count_q;

endmodule

// File: tb/tb_rshift_round_sat.sv
// Scoreboard bench for rshift_round_sat at DATA_WIDTH=16, RSHIFT_AMOUNT=8.
module tb_rshift_round_sat;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] D_in;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] D_out;
   logic        out_valid;
   logic        out_ready;
   logic        sat_flag;
   logic [7:0]  sat_count;
   logic        clr_count;

   rshift_round_sat #(.DATA_WIDTH(16), .RSHIFT_AMOUNT(8)) dut (
      .clk(clk), .rst_n(rst_n), .D_in(D_in), .in_valid(in_valid), .in_ready(in_ready),
      .D_out(D_out), .out_valid(out_valid), .out_ready(out_ready), .sat_flag(sat_flag),
      .sat_count(sat_count), .clr_count(clr_count));

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] d;
      logic        s;
      int          cyc;
   } exp_t;

   exp_t        q[$];
   int          n_chk = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          cnt_m = 0;
   bit          lat_chk = 0;
   bit          prev_stall = 0;
   logic [15:0] prev_d;
   logic        prev_s;
   bit          acc;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Reference: sign-extend, add half LSB, floor-shift, clamp.
   function automatic void model(input logic [31:0] din, output logic [15:0] d, output logic s);
      longint v;
      v = longint'($signed(din));
      v = (v + 128) >>> 8;
      s = 1'b1;
      if (v > 32767) d = 16'h7FFF;
      else if (v < -32768) d = 16'h8000;
      else begin
         d = v[15:0];
         s = 1'b0;
      end
   endfunction

   // Drive one cycle, then check outputs against the scoreboard before the next edge.
   task automatic step(input bit iv, input logic [31:0] din, input bit ordy, input bit clr,
                       input logic [15:0] ed, input logic es, output bit accepted);
      exp_t e;
      @(negedge clk);
      in_valid = iv; D_in = din; out_ready = ordy; clr_count = clr;
      #1;
      chk("sat_count", {24'b0, sat_count}, cnt_m[31:0]);
      if (!out_valid) chk("sat_flag_idle", {31'b0, sat_flag}, 32'd0);
      if (prev_stall) begin
         chk("hold_valid", {31'b0, out_valid}, 32'd1);
         chk("hold_dout", {16'b0, D_out}, {16'b0, prev_d});
         chk("hold_flag", {31'b0, sat_flag}, {31'b0, prev_s});
      end
      if (out_valid && !out_ready) chk("in_ready_stall", {31'b0, in_ready}, 32'd0);
      if (!out_valid) chk("in_ready_empty", {31'b0, in_ready}, 32'd1);
      accepted = iv && in_ready;
      if (accepted) begin
         e.d = ed; e.s = es; e.cyc = cyc;
         q.push_back(e);
      end
      if (out_valid && out_ready) begin
         if (q.size() == 0) chk("spurious_out", 32'd1, 32'd0);
         else begin
            e = q.pop_front();
            chk("dout", {16'b0, D_out}, {16'b0, e.d});
            chk("sat_flag", {31'b0, sat_flag}, {31'b0, e.s});
            if (lat_chk) chk("latency", cyc - e.cyc, 32'd2);
         end
      end
      if (clr) cnt_m = 0;
      else if (out_valid && out_ready && sat_flag && cnt_m < 255) cnt_m++;
      prev_stall = out_valid && !out_ready;
      prev_d = D_out; prev_s = sat_flag;
      cyc++;
   endtask

   task automatic step_m(input bit iv, input logic [31:0] din, input bit ordy, input bit clr,
                         output bit accepted);
      logic [15:0] d; logic s;
      model(din, d, s);
      step(iv, din, ordy, clr, d, s, accepted);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clr_count = 1'b0; D_in = '0;
      @(negedge clk);
      rst_n = 1'b1;
      q.delete(); cnt_m = 0; prev_stall = 0;
      #1;
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_dout", {16'b0, D_out}, 32'd0);
      chk("rst_sat_flag", {31'b0, sat_flag}, 32'd0);
      chk("rst_sat_count", {24'b0, sat_count}, 32'd0);
      chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && q.size() != 0; i++) step(0, '0, 1, 0, '0, 0, acc);
      chk("drain_empty", q.size(), 32'd0);
   endtask

   logic [31:0] dir_in [8] = '{32'h0000_0180, 32'h0000_017F, 32'hFFFF_FE80, 32'hFFFF_FE7F,
                               32'h7FFF_FFFF, 32'h8000_0000, 32'h007F_FF7F, 32'h0000_0000};
   logic [15:0] dir_d  [8] = '{16'h0002, 16'h0001, 16'hFFFF, 16'hFFFE,
                               16'h7FFF, 16'h8000, 16'h7FFF, 16'h0000};
   logic        dir_s  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clr_count = 1'b0; D_in = '0;
      repeat (2) @(negedge clk);
      do_reset();

      // Directed rounding/saturation values with fixed expectations and latency check.
      lat_chk = 1;
      for (int i = 0; i < 8; i++) step(1, dir_in[i], 1, 0, dir_d[i], dir_s[i], acc);
      drain();
      lat_chk = 0;
      chk("sat_count_two", {24'b0, sat_count}, 32'd2);

      // Backpressure: out_ready pattern 1,0,0 repeating; hold sample until accepted.
      begin
         int k = 0;
         logic [31:0] v;
         v = $urandom;
         for (int c = 0; c < 100 && k < 10; c++) begin
            step_m(1, v, (c % 3) == 0, 0, acc);
            if (acc) begin k++; v = $urandom; end
         end
         chk("bp_all_sent", k, 32'd10);
         drain();
      end

      // Counter saturation, then clear colliding with a saturating transfer.
      for (int i = 0; i < 300; i++) step_m(1, 32'h7FFF_FFFF, 1, 0, acc);
      step_m(1, 32'h7FFF_FFFF, 1, 0, acc);
      chk("sat_count_max", {24'b0, sat_count}, 32'd255);
      step_m(1, 32'h8000_0000, 1, 1, acc);
      step_m(0, '0, 1, 0, acc);
      drain();

      // Mid-stream reset with both stages full.
      step_m(1, 32'h8000_0000, 0, 0, acc);
      step_m(1, 32'h7FFF_FFFF, 0, 0, acc);
      step_m(1, 32'h0001_2345, 0, 0, acc);
      do_reset();
      for (int i = 0; i < 4; i++) step_m(0, '0, 1, 0, acc);

      // Random traffic with random bubbles and backpressure.
      for (int i = 0; i < 200; i++)
         step_m($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0,
                $urandom_range(0, 40) == 0, acc);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/rshift_round_sat.md
RSHIFT_ROUND_SAT -- requirements
Module: rshift_round_sat

Interface
REQ-001 Parameter DATA_WIDTH, default 16: output sample width; the input is 2*DATA_WIDTH bits wide.
REQ-002 Parameter RSHIFT_AMOUNT, default 8: arithmetic right-shift amount, legal range 0..DATA_WIDTH.
REQ-003 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1: reset, synchronous and active-low.
REQ-005 Port D_in  input  2*DATA_WIDTH: two's-complement wide sample, e.g. a product or accumulator.
REQ-006 Port in_valid  input  1: D_in is valid this cycle.
REQ-007 Port in_ready  output  1: block accepts D_in this cycle.
REQ-008 Port D_out  output  DATA_WIDTH: rounded, shifted and saturated two's-complement sample.
REQ-009 Port out_valid  output  1: D_out is valid.
REQ-010 Port out_ready  input  1: downstream accepts D_out.
REQ-011 Port sat_flag  output  1: the current D_out was clamped; qualified by out_valid.
REQ-012 Port sat_count  output  8: count of saturated samples transferred at the output.
REQ-013 Port clr_count  input  1: synchronous clear of sat_count.

Function
REQ-014 An input transfer SHALL occur when in_valid && in_ready; an output transfer SHALL occur when out_valid && out_ready.
REQ-015 The block SHALL be a two-stage pipeline, S1 (round+shift) and S2 (saturate/output register), with one global advance enable en = !out_valid || out_ready.
REQ-016 in_ready SHALL equal en (combinational); in_ready is 1 whenever S2 is empty, even if out_ready = 0.
REQ-017 When en = 1, S1 SHALL capture D_in and in_valid, and S2 SHALL capture S1; when en = 0, both stages SHALL hold, with D_out, sat_flag and out_valid stable.
REQ-018 Latency SHALL be exactly 2 cycles from input transfer to out_valid, with no output stall; sustained throughput SHALL be 1 sample/cycle while out_ready = 1.
REQ-019 Rounding SHALL be round-half-up (toward +inf).
  - Sign-extend the input to 2*DATA_WIDTH+1 bits.
  - Add 2^(RSHIFT_AMOUNT-1) when RSHIFT_AMOUNT > 0; no rounding add when RSHIFT_AMOUNT = 0.
  - Then shift arithmetically right by RSHIFT_AMOUNT.
  - No intermediate overflow SHALL be possible.
REQ-020 Saturation: a rounded value > 2^(DATA_WIDTH-1)-1 SHALL output 0x7FFF (generic: max positive), and one < -2^(DATA_WIDTH-1) SHALL output 0x8000 (min negative); sat_flag = 1 in both cases, else the low DATA_WIDTH bits pass and sat_flag = 0.
REQ-021 sat_flag SHALL be registered in S2 alongside D_out and SHALL be 0 whenever out_valid = 0.
REQ-022 sat_count update rules:
  - Increment by 1 on each output transfer with sat_flag = 1.
  - Saturate at 255 (no wrap).
  - clr_count = 1 forces 0 next cycle and has priority over a simultaneous increment.
REQ-023 Bubbles (in_valid = 0 while en = 1) SHALL propagate as out_valid = 0 and SHALL NOT change sat_count.
REQ-024 D_out/sat_flag contents when out_valid = 0 are don't-care except after reset (REQ-026).

Reset
REQ-025 While rst_n = 0 at a clock edge, the block SHALL clear S1 and S2 valid bits and set sat_count = 0.
REQ-026 After reset, D_out, sat_flag and out_valid SHALL read 0.
REQ-027 Reset asserted mid-stream SHALL discard all in-flight samples with no output transfer; in_ready SHALL be 1 in the first cycle after rst_n rises.

Verification (DATA_WIDTH = 16, RSHIFT_AMOUNT = 8)
REQ-028 Rounding, positive: D_in 0x00000180 (384) -> D_out 0x0002, sat_flag 0; D_in 0x0000017F -> 0x0001; both appear 2 cycles after transfer with out_ready = 1.
REQ-029 Rounding, negative: D_in 0xFFFFFE80 (-384) -> D_out 0xFFFF (-1); D_in 0xFFFFFE7F (-385) -> 0xFFFE (-2).
REQ-030 Saturation: D_in 0x7FFFFFFF -> 0x7FFF with sat_flag 1; D_in 0x80000000 -> 0x8000 with sat_flag 1; D_in 0x007FFF7F -> 0x7FFF with sat_flag 0; sat_count = 2 after both saturated transfers.
REQ-031 Backpressure:
  - Stream 10 samples with out_ready toggling 1,0,0,1,...
  - All 10 SHALL emerge in order, unduplicated and unchanged.
  - During out_ready = 0 with out_valid = 1, in_ready = 0 and D_out is held.
REQ-032 Counter:
  - 300 saturating transfers -> sat_count = 255.
  - clr_count asserted in the same cycle as a saturating transfer -> sat_count = 0 next cycle.
REQ-033 Reset mid-stream: with S1 and S2 full, pulse rst_n = 0 for one cycle -> out_valid = 0, sat_count = 0, and no stale sample is ever output.
